// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N:1 streaming multiplexer.
package mux_pkg;

    localparam int MODE_SEL = 0;
    localparam int MODE_RR  = 1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_any
);

    int idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!grant_any && req[idx]) begin
                grant_any  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/stream_mux_n.sv
// N:1 W-bit valid/ready stream mux with one registered output stage,
// selecting either by external sel or by round-robin arbitration.
module stream_mux_n
    import mux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_IN  = 4,
    parameter int SEL_W = clog2(N_IN),
    parameter int MODE  = MODE_SEL
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [N_IN-1:0]       in_valid,
    output logic [N_IN-1:0]       in_ready,
    input  logic [SEL_W-1:0]      sel,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SEL_W-1:0]      out_src
);

    logic [WIDTH-1:0] ch_data [N_IN];
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] out_src_q, out_src_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic [N_IN-1:0]  rr_grant;
    logic [SEL_W-1:0] rr_idx;
    logic             rr_any;

    logic             can_load;
    logic             pick_ok;
    logic [SEL_W-1:0] pick_idx;
    logic             xfer;

    for (genvar g = 0; g < N_IN; g++) begin : g_slice
        assign ch_data[g] = in_data[g*WIDTH +: WIDTH];
    end

    if (MODE == MODE_RR) begin : g_rr
        rr_arbiter #(.N(N_IN), .IW(SEL_W)) u_arb (
            .req       (in_valid),
            .ptr       (ptr_q),
            .grant     (rr_grant),
            .grant_idx (rr_idx),
            .grant_any (rr_any)
        );
    end else begin : g_no_rr
        assign rr_grant = '0;
        assign rr_idx   = '0;
        assign rr_any   = 1'b0;
    end

    assign can_load = ~out_valid_q | out_ready;

    // in_ready depends only on sel/grant and output state, never on data
    always_comb begin
        in_ready = '0;
        pick_idx = '0;
        pick_ok  = 1'b0;
        if (MODE == MODE_RR) begin
            pick_ok  = rr_any;
            pick_idx = rr_idx;
            in_ready = rr_grant & {N_IN{can_load}};
        end else begin
            pick_ok  = int'(sel) < N_IN;
            pick_idx = sel;
            if (pick_ok) in_ready[sel] = can_load;
        end
    end

    assign xfer = can_load & pick_ok & in_valid[pick_idx];

    always_comb begin
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            out_data_d  = ch_data[pick_idx];
            out_src_d   = pick_idx;
            out_valid_d = 1'b1;
            if (MODE == MODE_RR) begin
                if (int'(pick_idx) == N_IN - 1) ptr_d = '0;
                else                            ptr_d = pick_idx + 1'b1;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_src_q   <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_mux_n.sv
// Directed bench: select-mode, round-robin and out-of-range-select instances.
module tb_stream_mux_n;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // MODE 0, N=4
    logic [31:0] d0;
    logic [3:0]  v0, r0;
    logic [1:0]  s0, src0;
    logic [7:0]  od0;
    logic        ov0, or0;

    // MODE 1, N=4
    logic [31:0] d1;
    logic [3:0]  v1, r1;
    logic [1:0]  s1, src1;
    logic [7:0]  od1;
    logic        ov1, or1;

    // MODE 0, N=5 so that sel can exceed the channel count
    logic [39:0] d2;
    logic [4:0]  v2, r2;
    logic [2:0]  s2, src2;
    logic [7:0]  od2;
    logic        ov2, or2;

    stream_mux_n #(.WIDTH(8), .N_IN(4), .MODE(0)) dut0 (
        .clk(clk), .rst(rst), .in_data(d0), .in_valid(v0), .in_ready(r0),
        .sel(s0), .out_data(od0), .out_valid(ov0), .out_ready(or0),
        .out_src(src0)
    );

    stream_mux_n #(.WIDTH(8), .N_IN(4), .MODE(1)) dut1 (
        .clk(clk), .rst(rst), .in_data(d1), .in_valid(v1), .in_ready(r1),
        .sel(s1), .out_data(od1), .out_valid(ov1), .out_ready(or1),
        .out_src(src1)
    );

    stream_mux_n #(.WIDTH(8), .N_IN(5), .MODE(0)) dut2 (
        .clk(clk), .rst(rst), .in_data(d2), .in_valid(v2), .in_ready(r2),
        .sel(s2), .out_data(od2), .out_valid(ov2), .out_ready(or2),
        .out_src(src2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1;
        d0 = '0; v0 = '0; s0 = '0; or0 = 1'b0;
        d1 = '0; v1 = '0; s1 = '0; or1 = 1'b0;
        d2 = '0; v2 = '0; s2 = '0; or2 = 1'b0;
        tick();
        tick();
        chk("rst_valid0", 32'(ov0), 32'h0);
        chk("rst_data0", 32'(od0), 32'h0);
        chk("rst_src0", 32'(src0), 32'h0);
        rst = 1'b0;

        // T1: sel=2 passes channel 2
        s0 = 2'd2; v0 = 4'b0100; d0 = 32'h00A5_0000; or0 = 1'b1;
        settle();
        chk("t1_ready", 32'(r0), 32'h4);
        tick();
        chk("t1_data", 32'(od0), 32'hA5);
        chk("t1_src", 32'(src0), 32'h2);
        chk("t1_valid", 32'(ov0), 32'h1);

        // T2: replace A5 with 3C in the same cycle, then stall
        s0 = 2'd1; v0 = 4'b0010; d0 = 32'h0000_3C00; or0 = 1'b1;
        settle();
        chk("t2_ready_load", 32'(r0), 32'h2);
        tick();
        chk("t2_data", 32'(od0), 32'h3C);
        chk("t2_src", 32'(src0), 32'h1);
        s0 = 2'd0; v0 = 4'b0001; d0 = 32'h0000_005A; or0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("t2_stall_ready", 32'(r0), 32'h0);
            tick();
            chk("t2_stall_data", 32'(od0), 32'h3C);
            chk("t2_stall_valid", 32'(ov0), 32'h1);
            chk("t2_stall_src", 32'(src0), 32'h1);
        end
        or0 = 1'b1;
        settle();
        chk("t2_release_ready", 32'(r0), 32'h1);
        tick();
        chk("t2_next_data", 32'(od0), 32'h5A);
        chk("t2_next_valid", 32'(ov0), 32'h1);
        chk("t2_next_src", 32'(src0), 32'h0);
        v0 = 4'b0000;
        tick();
        chk("t2_drain_valid", 32'(ov0), 32'h0);
        chk("t2_drain_data", 32'(od0), 32'h5A);

        // T3: round-robin over all-valid channels
        d1 = 32'h1312_1110; v1 = 4'b1111; or1 = 1'b1;
        settle();
        chk("t3_first_ready", 32'(r1), 32'h1);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("t3_src", 32'(src1), 32'(k % 4));
            chk("t3_data", 32'(od1), 32'(8'h10 + k % 4));
            chk("t3_valid", 32'(ov1), 32'h1);
        end

        // T4: move ptr to 3, then wrap-around searches
        v1 = 4'b0100;
        tick();
        chk("t4_src_a", 32'(src1), 32'h2);
        v1 = 4'b0110;
        settle();
        chk("t4_ready_wrap", 32'(r1), 32'h2);
        tick();
        chk("t4_src_wrap", 32'(src1), 32'h1);
        settle();
        chk("t4_ready_next", 32'(r1), 32'h4);
        tick();
        chk("t4_src_next", 32'(src1), 32'h2);
        chk("t4_data_next", 32'(od1), 32'h12);

        // T5: sel beyond channel count selects nothing
        d2 = 40'h1514_1312_11; v2 = 5'b11111; or2 = 1'b1;
        s2 = 3'd5;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) s2 = 3'd7;
            settle();
            chk("t5_ready", 32'(r2), 32'h0);
            tick();
            chk("t5_valid", 32'(ov2), 32'h0);
        end
        s2 = 3'd4;
        settle();
        chk("t5_top_ready", 32'(r2), 32'h10);
        tick();
        chk("t5_top_src", 32'(src2), 32'h4);
        chk("t5_top_data", 32'(od2), 32'h15);
        v2 = '0;

        // T6: reset while holding a stalled beat (ptr is 3 here)
        v1 = 4'b1000;
        tick();
        chk("t6_pre_valid", 32'(ov1), 32'h1);
        chk("t6_pre_src", 32'(src1), 32'h3);
        v1 = 4'b0000; or1 = 1'b0; rst = 1'b1;
        tick();
        chk("t6_valid", 32'(ov1), 32'h0);
        chk("t6_data", 32'(od1), 32'h0);
        chk("t6_src", 32'(src1), 32'h0);
        rst = 1'b0;
        v1 = 4'b1111; or1 = 1'b1;
        settle();
        chk("t6_rr_ready", 32'(r1), 32'h1);
        tick();
        chk("t6_rr_src", 32'(src1), 32'h0);
        chk("t6_rr_data", 32'(od1), 32'h10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
